// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit, 4-register CPU.
// Owns pc/ir, drives register-file addressing, write-back and ALU op selection.
module control_unit #(
  parameter int                    PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0]   RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  output logic [PC_WIDTH-1:0] pc,
  input  logic [7:0]          instr_data,
  input  logic [7:0]          alu_result,
  output logic [2:0]          alu_op,
  output logic [1:0]          rf_read_addr1,
  output logic [1:0]          rf_read_addr2,
  output logic                rf_write_enable,
  output logic [1:0]          rf_write_addr,
  output logic [7:0]          rf_write_data,
  output logic                z_flag,
  output logic                halted,
  output logic [2:0]          state
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_FETCH_IMM = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_e;

  localparam logic [3:0] OP_LDI  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_JZ   = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_e              state_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic [7:0]          ir_q;
  logic [7:0]          imm_q;
  logic [7:0]          res_q;
  logic                z_q;
  logic                we_q;
  logic                halted_q;

  logic [3:0]          opcode;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] pc_imm;

  assign opcode = ir_q[7:4];
  assign pc_inc = pc_q + PC_WIDTH'(1);
  assign pc_imm = PC_WIDTH'(instr_data);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      imm_q    <= '0;
      res_q    <= '0;
      z_q      <= 1'b0;
      we_q     <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_FETCH: begin
          ir_q    <= instr_data;
          pc_q    <= pc_inc;
          we_q    <= 1'b0;
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          if (opcode >= 4'h1 && opcode <= 4'h6) begin
            state_q <= S_EXECUTE;
          end else if (opcode >= OP_LDI && opcode <= OP_JZ) begin
            state_q <= S_FETCH_IMM;
          end else if (opcode == OP_HALT) begin
            halted_q <= 1'b1;
            state_q  <= S_HALT;
          end else begin
            state_q <= S_FETCH;
          end
        end
        S_FETCH_IMM: begin
          imm_q <= instr_data;
          if (opcode == OP_LDI) begin
            pc_q    <= pc_inc;
            we_q    <= 1'b1;
            state_q <= S_WRITEBACK;
          end else if (opcode == OP_JMP) begin
            pc_q    <= pc_imm;
            state_q <= S_FETCH;
          end else begin
            // JZ uses the flag left by the last ALU instruction
            pc_q    <= z_q ? pc_imm : pc_inc;
            state_q <= S_FETCH;
          end
        end
        S_EXECUTE: begin
          res_q <= alu_result;
          if (opcode >= 4'h1 && opcode <= 4'h5) begin
            z_q <= (alu_result == 8'h00);
          end
          we_q    <= 1'b1;
          state_q <= S_WRITEBACK;
        end
        S_WRITEBACK: begin
          we_q    <= 1'b0;
          state_q <= S_FETCH;
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          we_q    <= 1'b0;
          state_q <= S_FETCH;
        end
      endcase
    end
  end

  always_comb begin
    alu_op = 3'd5;
    unique case (opcode)
      4'h1:    alu_op = 3'd0;
      4'h2:    alu_op = 3'd1;
      4'h3:    alu_op = 3'd2;
      4'h4:    alu_op = 3'd3;
      4'h5:    alu_op = 3'd4;
      default: alu_op = 3'd5;
    endcase
  end

  // Strobe is gated by reset so an aborted write-back never reaches the register file
  assign rf_write_enable = we_q & ~reset;
  assign rf_write_data   = (opcode == OP_LDI) ? imm_q : res_q;
  assign rf_read_addr1   = ir_q[3:2];
  assign rf_read_addr2   = ir_q[1:0];
  assign rf_write_addr   = ir_q[3:2];
  assign pc              = pc_q;
  assign z_flag          = z_q;
  assign halted          = halted_q;
  assign state           = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: ROM, register file and ALU environment around the DUT,
// checked against an instruction-level reference model.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] pc;
  logic [7:0] instr_data;
  logic [7:0] alu_result;
  logic [2:0] alu_op;
  logic [1:0] rf_read_addr1, rf_read_addr2, rf_write_addr;
  logic       rf_write_enable;
  logic [7:0] rf_write_data;
  logic       z_flag, halted;
  logic [2:0] state;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  control_unit #(.PC_WIDTH(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .reset(reset), .pc(pc), .instr_data(instr_data),
    .alu_result(alu_result), .alu_op(alu_op),
    .rf_read_addr1(rf_read_addr1), .rf_read_addr2(rf_read_addr2),
    .rf_write_enable(rf_write_enable), .rf_write_addr(rf_write_addr),
    .rf_write_data(rf_write_data), .z_flag(z_flag), .halted(halted),
    .state(state)
  );

  // Environment: asynchronous ROM, register file, ALU
  logic [7:0] rom [256];
  logic [7:0] rf [4] = '{default: 8'h00};
  logic [7:0] alu_a, alu_b;

  assign instr_data = rom[pc];

  always @(posedge clk) begin
    if (rf_write_enable === 1'b1) rf[rf_write_addr] <= rf_write_data;
  end

  always_comb begin
    alu_a = rf[rf_read_addr1];
    alu_b = rf[rf_read_addr2];
    case (alu_op)
      3'd0:    alu_result = alu_a + alu_b;
      3'd1:    alu_result = alu_a - alu_b;
      3'd2:    alu_result = alu_a & alu_b;
      3'd3:    alu_result = alu_a | alu_b;
      3'd4:    alu_result = alu_a ^ alu_b;
      default: alu_result = alu_b;
    endcase
  end

  // Reference model: architectural state and expected write-backs {addr, data}
  logic [7:0] m_pc = 8'h00;
  logic       m_z = 1'b0;
  logic       m_halt = 1'b0;
  logic [7:0] m_rf [4] = '{default: 8'h00};
  logic [9:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 8'h00;
    m_z = 1'b0;
    m_halt = 1'b0;
    exp_q.delete();
  endtask

  // Executes one instruction architecturally; returns its cycle count
  task automatic model_step(output int ncyc);
    logic [7:0] b, imm, r;
    logic [3:0] op;
    logic [1:0] rd, rs;
    b = rom[m_pc];
    op = b[7:4];
    rd = b[3:2];
    rs = b[1:0];
    m_pc = m_pc + 8'd1;
    ncyc = 2;
    case (op)
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
        case (op)
          4'h1:    r = m_rf[rd] + m_rf[rs];
          4'h2:    r = m_rf[rd] - m_rf[rs];
          4'h3:    r = m_rf[rd] & m_rf[rs];
          4'h4:    r = m_rf[rd] | m_rf[rs];
          default: r = m_rf[rd] ^ m_rf[rs];
        endcase
        m_z = (r == 8'h00);
        m_rf[rd] = r;
        exp_q.push_back({rd, r});
        ncyc = 4;
      end
      4'h6: begin
        r = m_rf[rs];
        m_rf[rd] = r;
        exp_q.push_back({rd, r});
        ncyc = 4;
      end
      4'h7: begin
        imm = rom[m_pc];
        m_pc = m_pc + 8'd1;
        m_rf[rd] = imm;
        exp_q.push_back({rd, imm});
        ncyc = 4;
      end
      4'h8: begin
        m_pc = rom[m_pc];
        ncyc = 3;
      end
      4'h9: begin
        imm = rom[m_pc];
        m_pc = m_z ? imm : m_pc + 8'd1;
        ncyc = 3;
      end
      4'hF: m_halt = 1'b1;
      default: ncyc = 2;
    endcase
  endtask

  // Runs one instruction from a negedge in FETCH to the negedge of the next boundary
  task automatic run_instr();
    int n;
    model_step(n);
    for (int i = 0; i < n; i++) begin
      if (rf_write_enable !== 1'b0) begin
        if (exp_q.size() == 0) chk("spurious_write", {22'd0, rf_write_addr, rf_write_data}, 32'h0);
        else chk("write", {22'd0, rf_write_addr, rf_write_data}, {22'd0, exp_q.pop_front()});
      end
      @(negedge clk);
    end
    chk("boundary_state", {29'd0, state}, m_halt ? 32'd5 : 32'd0);
    chk("boundary_pc", {24'd0, pc}, {24'd0, m_pc});
    chk("boundary_z", {31'd0, z_flag}, {31'd0, m_z});
    chk("boundary_halted", {31'd0, halted}, {31'd0, m_halt});
    chk("pending_writes", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_pc", {24'd0, pc}, 32'h0);
    chk("rst_state", {29'd0, state}, 32'h0);
    chk("rst_z", {31'd0, z_flag}, 32'h0);
    chk("rst_halted", {31'd0, halted}, 32'h0);
    chk("rst_we", {31'd0, rf_write_enable}, 32'h0);
    chk("rst_wdata_addrs", {18'd0, rf_write_data, rf_read_addr1, rf_read_addr2, rf_write_addr}, 32'h0);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
  endtask

  initial begin
    clear_rom();
    repeat (2) @(posedge clk);

    // Program: LDI R0,5; LDI R1,3; ADD R0,R1; HALT
    rom[0] = 8'h70; rom[1] = 8'h05; rom[2] = 8'h74; rom[3] = 8'h03;
    rom[4] = 8'h11; rom[5] = 8'hF0;
    do_reset();
    repeat (4) run_instr();
    chk("prog1_r0", {24'd0, rf[0]}, 32'h08);
    chk("prog1_r1", {24'd0, rf[1]}, 32'h03);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("halt_pc_frozen", {24'd0, pc}, 32'h06);
      chk("halt_state", {29'd0, state}, 32'd5);
      chk("halt_no_write", {31'd0, rf_write_enable}, 32'h0);
    end

    // LDI R2,7; SUB R2,R2; JZ 0x10 -> taken
    clear_rom();
    rom[0] = 8'h78; rom[1] = 8'h07; rom[2] = 8'h2A; rom[3] = 8'h90; rom[4] = 8'h10;
    do_reset();
    repeat (3) run_instr();
    chk("jz_taken_pc", {24'd0, pc}, 32'h10);
    chk("jz_taken_z", {31'd0, z_flag}, 32'h1);

    // LDI R2,7; OR R2,R2; JZ 0x10 -> falls through
    rom[2] = 8'h4A;
    do_reset();
    repeat (3) run_instr();
    chk("jz_fall_pc", {24'd0, pc}, 32'h05);

    // LDI R0,F0; LDI R1,0F; AND R0,R1; MOV R2,R1; NOP 0xB0; NOP 0x00
    clear_rom();
    rom[0] = 8'h70; rom[1] = 8'hF0; rom[2] = 8'h74; rom[3] = 8'h0F;
    rom[4] = 8'h31; rom[5] = 8'h69; rom[6] = 8'hB0; rom[7] = 8'h00;
    do_reset();
    repeat (6) run_instr();
    chk("and_zero_r0", {24'd0, rf[0]}, 32'h00);
    chk("mov_keeps_z", {31'd0, z_flag}, 32'h1);
    chk("mov_r2", {24'd0, rf[2]}, 32'h0F);

    // JMP 0xFE; NOPs at FE/FF wrap to 0; then LDI R3 at FE with immediate at FF
    clear_rom();
    rom[0] = 8'h80; rom[1] = 8'hFE;
    do_reset();
    repeat (3) run_instr();
    chk("wrap_pc", {24'd0, pc}, 32'h00);
    run_instr();
    rom[8'hFE] = 8'h7C; rom[8'hFF] = 8'h55;
    run_instr();
    chk("imm_at_ff_pc", {24'd0, pc}, 32'h00);
    chk("imm_at_ff_r3", {24'd0, rf[3]}, 32'h55);

    // Reset asserted during WRITEBACK of ADD aborts the write
    clear_rom();
    rom[0] = 8'h70; rom[1] = 8'h05; rom[2] = 8'h74; rom[3] = 8'h03; rom[4] = 8'h11;
    do_reset();
    repeat (2) run_instr();
    repeat (3) @(negedge clk);
    chk("abort_in_wb", {29'd0, state}, 32'd4);
    reset = 1'b1;
    #1;
    chk("abort_no_strobe", {31'd0, rf_write_enable}, 32'h0);
    @(negedge clk);
    chk("abort_pc", {24'd0, pc}, 32'h0);
    chk("abort_state", {29'd0, state}, 32'h0);
    chk("abort_z", {31'd0, z_flag}, 32'h0);
    chk("abort_r0_kept", {24'd0, rf[0]}, {24'd0, m_rf[0]});
    reset = 1'b0;
    model_reset();

    // Random programs without HALT
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 256; i++) begin
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        if (b[7:4] == 4'hF) b[7:4] = 4'h0;
        rom[i] = b;
      end
      do_reset();
      repeat (150) run_instr();
      for (int r = 0; r < 4; r++) chk("rand_rf", {24'd0, rf[r]}, {24'd0, m_rf[r]});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
